// File: rtl/serial_debug_arbiter.sv
// Round-robin arbiter that shares one serial_debug transmitter among NUM_REQ sources.
// It latches the winning message, pulses send, and tracks busy until the frame completes or times out.
module serial_debug_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int MSG_LEN   = 16,
    parameter int START_TMO = 15
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ*8*MSG_LEN-1:0] msg_in,
    output logic [NUM_REQ-1:0]           ack,
    output logic                         done,
    output logic                         err,
    output logic [$clog2(NUM_REQ)-1:0]   grant_id,
    output logic                         dbg_block,
    output logic                         dbg_send,
    output logic [8*MSG_LEN-1:0]         dbg_data,
    input  logic                         dbg_busy
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int DW    = 8 * MSG_LEN;
    localparam int CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_START,
        WAIT_DONE
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [CNT_W-1:0]   tmo_cnt;
    logic [CNT_W-1:0]   tmo_cnt_next;
    logic [NUM_REQ-1:0] ack_next;
    logic               done_next;
    logic               err_next;
    logic               send_next;
    logic               block_next;
    logic [ID_W-1:0]    grant_next;
    logic [DW-1:0]      data_next;
    logic [ID_W-1:0]    winner;
    logic               winner_valid;

    // Index that lies 'off' positions after 'base', wrapping at NUM_REQ.
    function automatic logic [ID_W-1:0] rr_index(input logic [ID_W-1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        if (sum >= NUM_REQ) begin
            sum = sum - NUM_REQ;
        end
        return ID_W'(sum);
    endfunction

    // Scan from the farthest offset down so the closest requester after grant_id wins.
    always_comb begin
        winner       = grant_id;
        winner_valid = 1'b0;
        for (int off = NUM_REQ; off >= 1; off--) begin
            if (req[rr_index(grant_id, off)]) begin
                winner       = rr_index(grant_id, off);
                winner_valid = 1'b1;
            end
        end
    end

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path leaves one unassigned and no latch is inferred.
        state_next   = state;
        tmo_cnt_next = tmo_cnt;
        ack_next     = '0;
        done_next    = 1'b0;
        err_next     = 1'b0;
        send_next    = 1'b0;
        block_next   = dbg_block;
        grant_next   = grant_id;
        data_next    = dbg_data;

        unique case (state)
            IDLE: begin
                block_next = ~en;
                if (en && winner_valid) begin
                    grant_next       = winner;
                    data_next        = msg_in[int'(winner)*DW +: DW];
                    ack_next[winner] = 1'b1;
                    send_next        = 1'b1;
                    tmo_cnt_next     = '0;
                    state_next       = WAIT_START;
                end
            end
            WAIT_START: begin
                // busy takes priority over an expiring timeout on the same edge
                if (dbg_busy) begin
                    state_next = WAIT_DONE;
                end else if (tmo_cnt == CNT_W'(START_TMO)) begin
                    err_next   = 1'b1;
                    state_next = IDLE;
                end else begin
                    tmo_cnt_next = tmo_cnt + CNT_W'(1);
                end
            end
            WAIT_DONE: begin
                if (!dbg_busy) begin
                    done_next  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            tmo_cnt   <= '0;
            ack       <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
            dbg_send  <= 1'b0;
            dbg_block <= 1'b1;
            grant_id  <= ID_W'(NUM_REQ - 1);
            // NOTE: the wide data register is reset as well, because its reset value is visible on the port.
            dbg_data  <= '0;
        end else begin
            // NOTE: non-blocking assignments make every register take its new value together at the edge.
            state     <= state_next;
            tmo_cnt   <= tmo_cnt_next;
            ack       <= ack_next;
            done      <= done_next;
            err       <= err_next;
            dbg_send  <= send_next;
            dbg_block <= block_next;
            grant_id  <= grant_next;
            dbg_data  <= data_next;
        end
    end

endmodule

// File: tb/tb_serial_debug_arbiter.sv
// Self-checking bench for serial_debug_arbiter: directed scenarios plus randomized frames,
// checked against a round-robin model and a behavioural serial_debug busy responder.
module tb_serial_debug_arbiter;

    localparam int NUM_REQ   = 4;
    localparam int MSG_LEN   = 16;
    localparam int START_TMO = 15;
    localparam int DW        = 8 * MSG_LEN;
    localparam int ID_W      = $clog2(NUM_REQ);

    logic                    clk      = 1'b0;
    logic                    rst      = 1'b1;
    logic                    en       = 1'b0;
    logic                    dbg_busy = 1'b0;
    logic [NUM_REQ-1:0]      req      = '0;
    logic [NUM_REQ*DW-1:0]   msg_in   = '0;
    logic [NUM_REQ-1:0]      ack;
    logic                    done;
    logic                    err;
    logic [ID_W-1:0]         grant_id;
    logic                    dbg_block;
    logic                    dbg_send;
    logic [DW-1:0]           dbg_data;

    logic [DW-1:0] msg [NUM_REQ];
    logic [DW-1:0] exp_data;
    int            last_grant;
    int            checks   = 0;
    int            failures = 0;
    int            order [5] = '{0, 1, 3, 0, 1};

    serial_debug_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .MSG_LEN  (MSG_LEN),
        .START_TMO(START_TMO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .req      (req),
        .msg_in   (msg_in),
        .ack      (ack),
        .done     (done),
        .err      (err),
        .grant_id (grant_id),
        .dbg_block(dbg_block),
        .dbg_send (dbg_send),
        .dbg_data (dbg_data),
        .dbg_busy (dbg_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DW-1:0] observed, input logic [DW-1:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] rand_msg();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic pack_msgs();
        for (int i = 0; i < NUM_REQ; i++) begin
            msg_in[i*DW +: DW] = msg[i];
        end
    endtask

    // Reference arbitration rule: first requester after the last grant, wrapping around.
    function automatic int rr_pick(input logic [NUM_REQ-1:0] r, input int last);
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (r[(last + k) % NUM_REQ]) begin
                return (last + k) % NUM_REQ;
            end
        end
        return -1;
    endfunction

    task automatic check_reset_values(input string tag);
        check({tag, ":ack"},      DW'(ack),       DW'(0));
        check({tag, ":done"},     DW'(done),      DW'(0));
        check({tag, ":err"},      DW'(err),       DW'(0));
        check({tag, ":send"},     DW'(dbg_send),  DW'(0));
        check({tag, ":data"},     dbg_data,       DW'(0));
        check({tag, ":block"},    DW'(dbg_block), DW'(1));
        check({tag, ":grant_id"}, DW'(grant_id),  DW'(NUM_REQ - 1));
    endtask

    // Outputs expected while a frame is in flight and nothing should pulse.
    task automatic frame_quiet(input string tag);
        check({tag, ":ack"},   DW'(ack),       DW'(0));
        check({tag, ":send"},  DW'(dbg_send),  DW'(0));
        check({tag, ":err"},   DW'(err),       DW'(0));
        check({tag, ":done"},  DW'(done),      DW'(0));
        check({tag, ":block"}, DW'(dbg_block), DW'(0));
        check({tag, ":data"},  dbg_data,       exp_data);
    endtask

    // Called while IDLE with en=1 and req nonzero; checks the grant cycle.
    task automatic grant_phase(input string tag, input bit hold_req);
        int                 w;
        logic [NUM_REQ-1:0] e_ack;
        w = rr_pick(req, last_grant);
        if (w < 0) begin
            w = 0;
        end
        exp_data = msg[w];
        e_ack    = NUM_REQ'(1) << w;
        step();
        check({tag, ":ack"},      DW'(ack),       DW'(e_ack));
        check({tag, ":send"},     DW'(dbg_send),  DW'(1));
        check({tag, ":grant_id"}, DW'(grant_id),  DW'(w));
        check({tag, ":data"},     dbg_data,       exp_data);
        check({tag, ":done"},     DW'(done),      DW'(0));
        check({tag, ":err"},      DW'(err),       DW'(0));
        check({tag, ":block"},    DW'(dbg_block), DW'(0));
        last_grant = w;
        if (!hold_req) begin
            req[w] = 1'b0;
        end
        msg[w] = rand_msg();
        pack_msgs();
    endtask

    // Behavioural serial_debug: busy rises 'delay' cycles after send, stays high 'len' cycles.
    task automatic busy_phase(input string tag, input int delay, input int len, input bit drop_en);
        for (int k = 0; k < delay; k++) begin
            step();
            frame_quiet({tag, ":pre"});
        end
        dbg_busy = 1'b1;
        if (drop_en) begin
            en = 1'b0;
        end
        for (int k = 0; k < len; k++) begin
            step();
            frame_quiet({tag, ":busy"});
        end
        dbg_busy = 1'b0;
        step();
        check({tag, ":done"}, DW'(done), DW'(1));
        check({tag, ":err"},  DW'(err),  DW'(0));
        check({tag, ":ack"},  DW'(ack),  DW'(0));
        check({tag, ":data"}, dbg_data,  exp_data);
    endtask

    // busy never rises: err must pulse exactly START_TMO+1 cycles after the send cycle.
    task automatic timeout_phase(input string tag);
        for (int k = 1; k <= START_TMO; k++) begin
            step();
            frame_quiet({tag, ":wait"});
        end
        step();
        check({tag, ":err"},  DW'(err),      DW'(1));
        check({tag, ":done"}, DW'(done),     DW'(0));
        check({tag, ":ack"},  DW'(ack),      DW'(0));
        check({tag, ":send"}, DW'(dbg_send), DW'(0));
    endtask

    initial begin
        for (int i = 0; i < NUM_REQ; i++) begin
            msg[i] = rand_msg();
        end
        pack_msgs();
        last_grant = NUM_REQ - 1;

        // Reset held for five cycles
        repeat (5) step();
        check_reset_values("reset");
        rst = 1'b0;
        step();
        check("idle_en0:block", DW'(dbg_block), DW'(1));
        check("idle_en0:ack",   DW'(ack),       DW'(0));
        en = 1'b1;
        step();
        check("idle_en1:block", DW'(dbg_block), DW'(0));
        check("idle_en1:send",  DW'(dbg_send),  DW'(0));

        // Single request from source 2 with a text message, 20-cycle busy
        msg[2] = "Time:  1000 \n";
        pack_msgs();
        req = 4'b0100;
        grant_phase("single", 1'b0);
        check("single:msg", dbg_data, DW'("Time:  1000 \n"));
        busy_phase("single", 2, 20, 1'b0);
        step();
        check("single:done_once", DW'(done), DW'(0));
        check("single:no_ack",    DW'(ack),  DW'(0));
        step();
        check("single:done_once2", DW'(done), DW'(0));

        // Fresh reset, then req=1011 held continuously
        rst = 1'b1;
        step();
        step();
        check_reset_values("reset2");
        rst        = 1'b0;
        last_grant = NUM_REQ - 1;
        req        = 4'b1011;
        for (int i = 0; i < 5; i++) begin
            grant_phase("held", 1'b1);
            check("held:order", DW'(grant_id), DW'(order[i]));
            busy_phase("held", int'($urandom_range(0, 4)), int'($urandom_range(1, 8)), 1'b0);
        end

        // busy stuck low: timeout, then the next requester is granted
        req = 4'b0101;
        grant_phase("tmo", 1'b0);
        timeout_phase("tmo");
        grant_phase("after_tmo", 1'b0);
        check("after_tmo:grant_id", DW'(grant_id), DW'(0));
        busy_phase("after_tmo", 15, 3, 1'b0);

        // en dropped during WAIT_DONE: frame completes, then no grants
        req = 4'b1111;
        grant_phase("en_drop", 1'b1);
        busy_phase("en_drop", 1, 5, 1'b1);
        check("en_drop:block_late", DW'(dbg_block), DW'(0));
        step();
        check("en_drop:block", DW'(dbg_block), DW'(1));
        check("en_drop:ack",   DW'(ack),       DW'(0));
        repeat (4) begin
            step();
            check("en_off:ack",   DW'(ack),       DW'(0));
            check("en_off:send",  DW'(dbg_send),  DW'(0));
            check("en_off:block", DW'(dbg_block), DW'(1));
        end
        en = 1'b1;

        // Reset five cycles into WAIT_DONE
        grant_phase("mid_rst", 1'b0);
        step();
        frame_quiet("mid_rst:start");
        dbg_busy = 1'b1;
        step();
        frame_quiet("mid_rst:busy");
        repeat (4) begin
            step();
            frame_quiet("mid_rst:busy");
        end
        rst = 1'b1;
        step();
        check_reset_values("mid_rst");
        dbg_busy = 1'b0;
        step();
        check_reset_values("mid_rst_hold");
        rst        = 1'b0;
        last_grant = NUM_REQ - 1;
        grant_phase("post_rst", 1'b0);
        check("post_rst:grant_id", DW'(grant_id), DW'(0));
        busy_phase("post_rst", 0, 4, 1'b0);

        // Randomized frames
        for (int n = 0; n < 40; n++) begin
            req = NUM_REQ'($urandom_range(1, (1 << NUM_REQ) - 1));
            grant_phase("rand", 1'b0);
            if ($urandom_range(0, 5) == 0) begin
                timeout_phase("rand_tmo");
            end else begin
                busy_phase("rand", int'($urandom_range(0, START_TMO)), int'($urandom_range(1, 12)), 1'b0);
            end
        end

        req = '0;
        step();
        check("final:ack",  DW'(ack),  DW'(0));
        check("final:done", DW'(done), DW'(0));
        step();
        check("final:send", DW'(dbg_send), DW'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
